// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between a requester and serial_addsub.
interface serial_addsub_if
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;
    logic             o_zero;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_valid, o_sum,
        input  o_carry, o_overflow, o_zero
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_valid, o_sum,
        output o_carry, o_overflow, o_zero
    );

endinterface

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
    input  logic X,
    input  logic Y,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = X ^ Y ^ Ci;
    assign Co = (X & Y) | (Ci & (X ^ Y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial A+B / A-B, one bit per cycle, LSB first.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic            i_clk,
    input logic            i_reset,
    serial_addsub_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt_q;
    logic             cy_q;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    fulladder u_fa (
        .X  (a_q[0]),
        .Y  (b_q[0]),
        .Ci (cy_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    assign res_nxt = {fa_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        a_q   <= bus.i_a;
                        // Subtract as A + ~B + 1.
                        b_q   <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        cy_q  <= bus.i_sub;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    res_q <= res_nxt;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cy_q  <= fa_co;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_nxt;
                        carry_q <= fa_co;
                        // cy_q is the carry into the MSB here.
                        ovf_q   <= cy_q ^ fa_co;
                        zero_q  <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_valid    = (state_q == DONE);
    assign bus.o_sum      = sum_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_zero     = zero_q;

endmodule
